// File: rtl/drygascon_g128.sv
// DryGASCON G-function stage: ROUNDS Gascon core rounds on the mixed state,
// XOR-folding state words 0..3 into a 128-bit accumulator after every round.

module Gascon_Core_Round #(
    parameter int ROUND_COUNT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [319:0] c,
    input  logic [3:0]   round,
    output logic [319:0] cout,
    output logic         done
);

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] gascon_round(input logic [319:0] s, input logic [3:0] rc);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[63:0];
        x1 = s[127:64];
        x2 = s[191:128];
        x3 = s[255:192];
        x4 = s[319:256];
        x2 = x2 ^ {56'd0, 4'(4'hf - rc), rc};
        // 5-bit S-box applied bit-sliced across the 64 columns
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x1 & x2;
        t1 = ~x2 & x3;
        t2 = ~x3 & x4;
        t3 = ~x4 & x0;
        t4 = ~x0 & x1;
        x0 = x0 ^ t0;
        x1 = x1 ^ t1;
        x2 = x2 ^ t2;
        x3 = x3 ^ t3;
        x4 = x4 ^ t4;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 38);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 40);
        return {x4, x3, x2, x1, x0};
    endfunction

    logic [319:0] nxt;

    always_comb begin
        nxt = c;
        for (int i = 0; i < ROUND_COUNT; i++)
            nxt = gascon_round(nxt, round + 4'(i));
    end

    // Result is taken once per en burst; done stays high until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cout <= '0;
            done <= 1'b0;
        end else if (en && !done) begin
            cout <= nxt;
            done <= 1'b1;
        end
    end

endmodule

module drygascon_g128 #(
    parameter int CWIDTH = 320,
    parameter int ROUNDS = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [CWIDTH-1:0] c,
    output logic [CWIDTH-1:0] cout,
    output logic [127:0]      r,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAITRND = 3'd3,
        ACC     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state;
    logic [CWIDTH-1:0] cReg;
    logic [127:0]      rReg;
    logic [3:0]        k;
    logic              coreReset, core_en, core_done;
    logic [319:0]      core_c, core_cout;
    logic [CWIDTH-1:0] c_next;
    logic [127:0]      fold;

    assign coreReset = (state == START);
    assign core_en   = (state == WAITRND);
    assign fold      = rReg ^ cReg[127:0] ^ cReg[255:128];

    // The core permutes a 320-bit state; wider states carry their top bits through.
    generate
        if (CWIDTH > 320) begin : g_wide
            assign core_c = cReg[319:0];
            assign c_next = {cReg[CWIDTH-1:320], core_cout};
        end else if (CWIDTH == 320) begin : g_exact
            assign core_c = cReg;
            assign c_next = core_cout;
        end else begin : g_narrow
            assign core_c = {{(320-CWIDTH){1'b0}}, cReg};
            assign c_next = core_cout[CWIDTH-1:0];
        end
    endgenerate

    Gascon_Core_Round #(.ROUND_COUNT(1)) u_core (
        .clk   (clk),
        .reset (reset | coreReset),
        .en    (core_en),
        .c     (core_c),
        .round (k),
        .cout  (core_cout),
        .done  (core_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cReg  <= '0;
            rReg  <= '0;
            k     <= '0;
            done  <= 1'b0;
            cout  <= '0;
            r     <= '0;
        end else begin
            case (state)
                IDLE: if (en) state <= LOAD;
                LOAD: begin
                    cReg  <= c;
                    rReg  <= '0;
                    k     <= '0;
                    state <= START;
                end
                START: state <= WAITRND;
                WAITRND: if (core_done) begin
                    cReg  <= c_next;
                    state <= ACC;
                end
                ACC: begin
                    rReg <= fold;
                    if (k == 4'(ROUNDS - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        cout  <= cReg;
                        r     <= fold;
                    end else begin
                        k     <= k + 4'd1;
                        state <= START;
                    end
                end
                DONE: if (!en) begin
                    state <= IDLE;
                    done  <= 1'b0;
                    cout  <= '0;
                    r     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
